frame_shadow_config_mem: RTL and testbench

FRAME_SHADOW_CONFIG_MEM -- requirements
Module: frame_shadow_config_mem

---
 rtl/frame_shadow_config_mem.sv | 208 ++++++++++++++++++++
 tb/tb_frame_shadow_config_mem.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_shadow_config_mem.sv
// ---------------------------------------------------------------------------
// frame_shadow_config_mem
//
// Double-buffered configuration frame store. Frames are written into a
// shadow bank on the rising edge of their individual strobe bit. A commit
// then copies the shadow bank into the active bank one frame per cycle,
// frame 0 first. The active bank drives the exported configuration bits.
//
// Optional feature (macro FRAME_READBACK_EN):
//   defined   : ReadbackData = active[ReadbackSel], registered, 1-cycle
//               latency; zero when ReadbackSel >= MaxFramesPerCol.
//   undefined : ReadbackData is tied to zero and ReadbackSel is ignored.
//
// Ports:
//   UserCLK       in   1                  sole clock, rising edge
//   resetn        in   1                  asynchronous active-low reset
//   FrameData     in   FrameBitsPerRow    shadow frame write data
//   FrameStrobe   in   MaxFramesPerCol    per-frame write strobes
//   Commit        in   1                  start shadow->active copy
//   Busy          out  1                  copy in progress
//   CommitDone    out  1                  one-cycle pulse after last copy
//   ReadbackSel   in   SelW               active frame index to read back
//   ReadbackData  out  FrameBitsPerRow    registered readback data
//   ConfigBits    out  CfgW               active configuration bits
//   ConfigBits_N  out  CfgW               complement of ConfigBits
//
// With NoConfigBits = 0 the ConfigBits ports keep a single bit tied to 0
// (and ConfigBits_N to 1), since a zero-width port cannot be declared.
// ---------------------------------------------------------------------------
module frame_shadow_config_mem #(
  parameter int  MaxFramesPerCol = 20,
  parameter int  FrameBitsPerRow = 32,
  parameter int  NoConfigBits    = 640,
  localparam int SelW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1,
  localparam int CfgW = (NoConfigBits > 0) ? NoConfigBits : 1
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic                       Commit,
  output logic                       Busy,
  output logic                       CommitDone,
  input  logic [SelW-1:0]            ReadbackSel,
  output logic [FrameBitsPerRow-1:0] ReadbackData,
  output logic [CfgW-1:0]            ConfigBits,
  output logic [CfgW-1:0]            ConfigBits_N
);

  localparam int TotalBits = MaxFramesPerCol * FrameBitsPerRow;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_COPY = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [SelW-1:0]            idx_q, idx_d;
  logic                       done_q, done_d;
  logic                       copy_en;

  logic [MaxFramesPerCol-1:0] strobe_q;
  logic [MaxFramesPerCol-1:0] strobe_rise;

  logic [FrameBitsPerRow-1:0] shadow_q [MaxFramesPerCol];
  logic [FrameBitsPerRow-1:0] active_q [MaxFramesPerCol];
  logic [TotalBits-1:0]       active_flat;

  // -------------------------------------------------------------------------
  // Strobe edge detection: only a 0->1 transition writes, a held level does not.
  // -------------------------------------------------------------------------
  assign strobe_rise = FrameStrobe & ~strobe_q;

  // NOTE: sequential state is always updated with non-blocking (<=)
  // assignments so every register samples pre-edge values; this is also what
  // makes a same-edge write+copy load the old shadow value into active.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= FrameStrobe;
    end
  end

  // -------------------------------------------------------------------------
  // Shadow bank. Several strobes rising together all take the same data.
  // NOTE: both banks are built from flops (not RAM macros), so they can and
  // must be cleared by the asynchronous reset; a RAM could not be.
  // -------------------------------------------------------------------------
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        if (strobe_rise[i]) begin
          shadow_q[i] <= FrameData;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Active bank: one frame per cycle while copying.
  // -------------------------------------------------------------------------
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        active_q[i] <= '0;
      end
    end else if (copy_en) begin
      active_q[idx_q] <= shadow_q[idx_q];
    end
  end

  // -------------------------------------------------------------------------
  // Commit sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    copy_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Commit is only looked at here, so a request while busy is dropped.
        if (Commit) begin
          state_d = S_COPY;
          idx_d   = '0;
        end
      end
      S_COPY: begin
        copy_en = 1'b1;
        if (idx_q == SelW'(MaxFramesPerCol - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + SelW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy       = (state_q == S_COPY);
  assign CommitDone = done_q;

  // -------------------------------------------------------------------------
  // Configuration bit export: bit k = frame k/FrameBitsPerRow, bit k%FrameBitsPerRow.
  // -------------------------------------------------------------------------
  for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_flat
    assign active_flat[f*FrameBitsPerRow +: FrameBitsPerRow] = active_q[f];
  end

  if (NoConfigBits == 0) begin : g_cfg_none
    logic unused_cfg;
    assign unused_cfg   = ^active_flat;
    assign ConfigBits   = '0;
  end else if (NoConfigBits < TotalBits) begin : g_cfg_part
    logic unused_cfg;
    assign unused_cfg   = ^active_flat[TotalBits-1:NoConfigBits];
    assign ConfigBits   = active_flat[NoConfigBits-1:0];
  end else begin : g_cfg_full
    assign ConfigBits   = active_flat;
  end

  assign ConfigBits_N = ~ConfigBits;

  // -------------------------------------------------------------------------
  // Optional readback
  // -------------------------------------------------------------------------
`ifdef FRAME_READBACK_EN
  logic [FrameBitsPerRow-1:0] rb_q;

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      rb_q <= '0;
    end else if (32'(ReadbackSel) < MaxFramesPerCol) begin
      rb_q <= active_q[ReadbackSel];
    end else begin
      rb_q <= '0;
    end
  end

  assign ReadbackData = rb_q;
`else
  logic unused_sel;
  assign unused_sel   = ^ReadbackSel;
  assign ReadbackData = '0;
`endif

endmodule

// File: tb/tb_frame_shadow_config_mem.sv
// ---------------------------------------------------------------------------
// tb_frame_shadow_config_mem
//
// Self-checking bench for frame_shadow_config_mem (default parameters).
// A reference model tracks shadow/active frames with plain arrays and
// derives Busy/CommitDone/copy slots from the edge number at which the
// accepted commit was sampled. Define FRAME_READBACK_EN for both the DUT
// and this bench to exercise readback.
// ---------------------------------------------------------------------------
module tb_frame_shadow_config_mem;

  localparam int N   = 20;
  localparam int W   = 32;
  localparam int CFG = 640;

  logic           clk;
  logic           resetn;
  logic [W-1:0]   FrameData;
  logic [N-1:0]   FrameStrobe;
  logic           Commit;
  logic           Busy;
  logic           CommitDone;
  logic [4:0]     ReadbackSel;
  logic [W-1:0]   ReadbackData;
  logic [CFG-1:0] ConfigBits;
  logic [CFG-1:0] ConfigBits_N;

  frame_shadow_config_mem #(
    .MaxFramesPerCol(N),
    .FrameBitsPerRow(W),
    .NoConfigBits   (CFG)
  ) dut (
    .UserCLK     (clk),
    .resetn      (resetn),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .Commit      (Commit),
    .Busy        (Busy),
    .CommitDone  (CommitDone),
    .ReadbackSel (ReadbackSel),
    .ReadbackData(ReadbackData),
    .ConfigBits  (ConfigBits),
    .ConfigBits_N(ConfigBits_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [CFG-1:0] act,
                       input logic [CFG-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] shadow_m [N];
  logic [W-1:0] active_m [N];
  logic [N-1:0] prev_strobe_m;
  logic [W-1:0] rb_m;
  int           edge_n;
  int           c_edge;   // edge at which the running/last commit was accepted

  function automatic logic [CFG-1:0] model_cfg();
    logic [CFG-1:0] v;
    v = '0;
    for (int f = 0; f < N; f++) v[f*W +: W] = active_m[f];
    return v;
  endfunction

  function automatic logic busy_after(input int e);
    return (c_edge <= e) && (e < c_edge + N);
  endfunction

  task automatic model_reset();
    for (int f = 0; f < N; f++) begin
      shadow_m[f] = '0;
      active_m[f] = '0;
    end
    prev_strobe_m = '0;
    rb_m          = '0;
    c_edge        = -1000;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_busy"}, CFG'(Busy), CFG'(busy_after(edge_n)));
    check({tag, "_done"}, CFG'(CommitDone), CFG'(edge_n == c_edge + N));
    check({tag, "_cfg"}, ConfigBits, model_cfg());
    check({tag, "_cfg_n"}, ConfigBits_N, ~model_cfg());
    check({tag, "_rb"}, CFG'(ReadbackData), CFG'(rb_m));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check after.
  task automatic step(input logic [W-1:0] d, input logic [N-1:0] s,
                      input logic c, input logic [4:0] sel);
    int f;
    FrameData   = d;
    FrameStrobe = s;
    Commit      = c;
    ReadbackSel = sel;
    @(posedge clk);
    edge_n++;
`ifdef FRAME_READBACK_EN
    rb_m = (int'(sel) < N) ? active_m[sel] : '0;
`else
    rb_m = '0;
`endif
    if (c && !busy_after(edge_n - 1)) c_edge = edge_n;
    // Copy slot for this edge uses the shadow value from before any write.
    f = edge_n - c_edge - 1;
    if (f >= 0 && f < N) active_m[f] = shadow_m[f];
    for (int i = 0; i < N; i++) begin
      if (s[i] && !prev_strobe_m[i]) shadow_m[i] = d;
    end
    prev_strobe_m = s;
    #1;
    check_outputs("step");
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step('0, '0, 1'b0, 5'd0);
  endtask

  task automatic run_until_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step('0, '0, 1'b0, 5'd0);
      seen = CommitDone;
    end
    check("done_within_budget", CFG'(seen), CFG'(1'b1));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] data;
    logic [N-1:0] strobe;
    logic         commit;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  initial begin
    // Entries 0..4: strobe 0 held high with changing data (first value wins).
    // Entry 5: commit -> busy after entries 5..24, second commit at 9 ignored,
    // done after entry 25 only.
    for (int k = 0; k < NV; k++) begin
      vecs[k].data     = (k < 5) ? (32'h1111_0000 + 32'(k) + 1) : 32'hFFFF_FFFF;
      vecs[k].strobe   = (k < 5) ? 20'h00001 : 20'h00000;
      vecs[k].commit   = (k == 5) || (k == 9);
      vecs[k].exp_busy = (k >= 5) && (k <= 24);
      vecs[k].exp_done = (k == 25);
    end

    FrameData   = '0;
    FrameStrobe = '0;
    Commit      = 1'b0;
    ReadbackSel = '0;
    edge_n      = 0;
    model_reset();

    // Reset state
    resetn = 1'b0;
    #12;
    check("rst_busy", CFG'(Busy), '0);
    check("rst_done", CFG'(CommitDone), '0);
    check("rst_cfg", ConfigBits, '0);
    check("rst_cfg_n", ConfigBits_N, '1);
    check("rst_rb", CFG'(ReadbackData), '0);
    #10 resetn = 1'b1;
    idle(2);

    // Table: held strobe + commit timing + ignored second commit
    for (int k = 0; k < NV; k++) begin
      step(vecs[k].data, vecs[k].strobe, vecs[k].commit, 5'd0);
      check($sformatf("tbl%0d_busy", k), CFG'(Busy), CFG'(vecs[k].exp_busy));
      check($sformatf("tbl%0d_done", k), CFG'(CommitDone), CFG'(vecs[k].exp_done));
    end
    check("held_strobe_frame0", CFG'(ConfigBits[31:0]), CFG'(32'h1111_0001));

    // Frame 3 write then commit
    step(32'hA5A5_0F0F, 20'h00008, 1'b0, 5'd0);
    step(32'h0, 20'h0, 1'b1, 5'd0);
    run_until_done();
    check("frame3_cfg", CFG'(ConfigBits[127:96]), CFG'(32'hA5A5_0F0F));
    check("frame3_cfg_n", CFG'(ConfigBits_N[127:96]), CFG'(32'h5A5A_F0F0));

    // Broadcast write to frames 2, 7, 15, then commit
    step(32'h1234_5678, 20'h08084, 1'b0, 5'd0);
    step(32'h0, 20'h0, 1'b1, 5'd0);
    run_until_done();
    check("bcast_frame2", CFG'(ConfigBits[95:64]), CFG'(32'h1234_5678));
    check("bcast_frame7", CFG'(ConfigBits[255:224]), CFG'(32'h1234_5678));
    check("bcast_frame15", CFG'(ConfigBits[511:480]), CFG'(32'h1234_5678));

    // Writes during COPY: frame 2 at copy index 2, frame 15 at copy index 5
    step(32'h0, 20'h0, 1'b1, 5'd0);                 // commit accepted (edge c)
    step(32'h0, 20'h0, 1'b0, 5'd0);                 // copy 0
    step(32'h0, 20'h0, 1'b0, 5'd0);                 // copy 1
    step(32'hDEAD_0002, 20'h00004, 1'b0, 5'd0);     // copy 2 + write frame 2
    step(32'h0, 20'h0, 1'b0, 5'd0);                 // copy 3
    step(32'h0, 20'h0, 1'b0, 5'd0);                 // copy 4
    step(32'hBEEF_0015, 20'h08000, 1'b0, 5'd0);     // copy 5 + write frame 15
    run_until_done();
    check("copy_frame2_old", CFG'(ConfigBits[95:64]), CFG'(32'h1234_5678));
    check("copy_frame15_new", CFG'(ConfigBits[511:480]), CFG'(32'hBEEF_0015));
    step(32'h0, 20'h0, 1'b1, 5'd0);
    run_until_done();
    check("recommit_frame2", CFG'(ConfigBits[95:64]), CFG'(32'hDEAD_0002));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] s;
      s = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step($urandom, s, ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)));
    end
    idle(25);

    // Reset in the middle of a commit (just before copy index 10)
    step(32'h0, 20'h0, 1'b1, 5'd0);
    idle(10);
    check("pre_rst_busy", CFG'(Busy), CFG'(1'b1));
    #3 resetn = 1'b0;
    #1;
    model_reset();
    check("midrst_busy", CFG'(Busy), '0);
    check("midrst_done", CFG'(CommitDone), '0);
    check("midrst_cfg", ConfigBits, '0);
    check("midrst_cfg_n", ConfigBits_N, '1);
    #2 resetn = 1'b1;
    idle(2);
    step(32'h0, 20'h0, 1'b1, 5'd0);
    run_until_done();
    check("post_rst_cfg", ConfigBits, '0);

    // Readback
    step(32'h7777_ABCD, 20'h00080, 1'b0, 5'd0);
    step(32'h0, 20'h0, 1'b1, 5'd0);
    run_until_done();
    step(32'h0, 20'h0, 1'b0, 5'd7);
`ifdef FRAME_READBACK_EN
    check("rb_sel7", CFG'(ReadbackData), CFG'(32'h7777_ABCD));
`else
    check("rb_sel7", CFG'(ReadbackData), '0);
`endif
    step(32'h0, 20'h0, 1'b0, 5'd25);
    check("rb_sel25", CFG'(ReadbackData), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
